// File: rtl/cfu_types.sv
// Shared types for the axi64 slave memory.
// Holds the AXI response and burst encodings, the only supported beat size,
// the slave FSM state enum, and a helper that classifies a burst command.
package cfu_types;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    // 8 bytes per beat
    localparam logic [2:0] SizeDword = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StWresp
    } slv_state_e;

    // FIXED is served as INCR, so only WRAP and non-8-byte sizes are rejected.
    function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
        return (size == SizeDword) && (burst != BurstWrap);
    endfunction

endpackage

// File: rtl/axi64_interface.sv
// AXI4 64-bit bus bundle (AR, R, AW, W, B channels).
// Ports: master drives requests, W data and rready/bready; slave drives
// arready/awready/wready and the R and B channels.
interface axi64_interface #(
    parameter int unsigned ID_WIDTH = 6
) ();
    logic [31:0]         araddr;
    logic [ID_WIDTH-1:0] arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arcache;
    logic                arvalid;
    logic                arready;

    logic [63:0]         rdata;
    logic [ID_WIDTH-1:0] rid;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [31:0]         awaddr;
    logic [ID_WIDTH-1:0] awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic                awvalid;
    logic                awready;

    logic [63:0]         wdata;
    logic [7:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arcache, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arcache, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/byte_en_ram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read.
// Ports: clk; en (access strobe); we (1 = write, 0 = read); be (byte enables);
// addr (word index); wdata; rdata (valid the cycle after a read, then held).
// Contents are never reset.
module byte_en_ram #(
    parameter int unsigned WORDS  = 8192,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [7:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axi64_slave_ram.sv
// AXI4 64-bit slave memory: serves one INCR/FIXED burst at a time from a
// single-ported byte-enabled RAM, with read/write arbitration and a 2-entry
// R buffer (the RAM output register plus one skid register).
// Ports: clk; rst (synchronous, active-high); axi64 (slave side of the bus).
module axi64_slave_ram
    import cfu_types::*;
#(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned ID_WIDTH  = 6
) (
    input logic           clk,
    input logic           rst,
    axi64_interface.slave axi64
);

    localparam int unsigned WORDS   = MEM_BYTES / 8;
    localparam int unsigned WADDR_W = $clog2(WORDS);

    slv_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [WADDR_W-1:0]  base_q, base_d;
    logic [7:0]          len_q, len_d;
    logic                err_q, err_d;
    logic                wl_err_q, wl_err_d;
    logic [8:0]          beat_q, beat_d;
    logic                last_grant_q, last_grant_d;   // 1 = last grant went to write
    logic                sk_v_q, sk_v_d;
    logic [63:0]         sk_data_q, sk_data_d;
    logic                sk_last_q, sk_last_d;
    logic                ram_v_q, ram_v_d;               // RAM output register holds a beat
    logic                ram_last_q, ram_last_d;

    logic               ram_en, ram_we;
    logic [7:0]         ram_be;
    logic [WADDR_W-1:0] ram_addr;
    logic [63:0]        ram_rdata;

    logic        gnt_rd, gnt_wr, beat_is_last;
    logic        r_valid, pop, issue, ram_pop, sk_pop, move;
    logic [63:0] ram_head, head_data;
    logic        head_last;

    logic unused_sig;
    assign unused_sig = ^{axi64.arcache, axi64.awcache, axi64.araddr[2:0], axi64.awaddr[2:0],
                          axi64.araddr[31:WADDR_W+3], axi64.awaddr[31:WADDR_W+3]};

    byte_en_ram #(
        .WORDS  (WORDS),
        .ADDR_W (WADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (axi64.wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        base_d       = base_q;
        len_d        = len_q;
        err_d        = err_q;
        wl_err_d     = wl_err_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;

        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = '0;
        ram_addr = base_q + WADDR_W'(beat_q);
        beat_is_last = (beat_q[7:0] == len_q);

        axi64.arready = 1'b0;
        axi64.awready = 1'b0;
        axi64.wready  = 1'b0;
        axi64.bvalid  = 1'b0;
        axi64.bresp   = RespOkay;
        axi64.bid     = id_q;

        // Ties alternate: read wins unless the read won last time.
        gnt_rd = axi64.arvalid && (!axi64.awvalid || last_grant_q);
        gnt_wr = axi64.awvalid && !gnt_rd;

        // R head: skid register is older than the RAM output when both are valid.
        ram_head  = err_q ? '0 : ram_rdata;
        r_valid   = sk_v_q || ram_v_q;
        head_data = sk_v_q ? sk_data_q : ram_head;
        head_last = sk_v_q ? sk_last_q : ram_last_q;
        axi64.rvalid = r_valid;
        axi64.rdata  = r_valid ? head_data : '0;
        axi64.rlast  = r_valid && head_last;
        axi64.rresp  = (r_valid && err_q) ? RespSlverr : RespOkay;
        axi64.rid    = id_q;

        pop     = r_valid && axi64.rready;
        ram_pop = pop && !sk_v_q;
        sk_pop  = pop && sk_v_q;
        // A new RAM read may overwrite the RAM output only if that beat is popped or parked.
        issue   = (state_q == StRd) && (beat_q <= {1'b0, len_q})
                  && !(ram_v_q && sk_v_q && !pop);
        move    = issue && ram_v_q && !ram_pop;

        sk_v_d     = (sk_v_q && !sk_pop) || move;
        sk_data_d  = move ? ram_head : sk_data_q;
        sk_last_d  = move ? ram_last_q : sk_last_q;
        ram_v_d    = issue || (ram_v_q && !ram_pop && !move);
        ram_last_d = issue ? beat_is_last : ram_last_q;

        unique case (state_q)
            StIdle: begin
                axi64.arready = gnt_rd;
                axi64.awready = gnt_wr;
                if (gnt_rd) begin
                    id_d         = axi64.arid;
                    base_d       = axi64.araddr[WADDR_W+2:3];
                    len_d        = axi64.arlen;
                    err_d        = !burst_ok(axi64.arsize, axi64.arburst);
                    wl_err_d     = 1'b0;
                    beat_d       = '0;
                    last_grant_d = 1'b0;
                    state_d      = StRd;
                end else if (gnt_wr) begin
                    id_d         = axi64.awid;
                    base_d       = axi64.awaddr[WADDR_W+2:3];
                    len_d        = axi64.awlen;
                    err_d        = !burst_ok(axi64.awsize, axi64.awburst);
                    wl_err_d     = 1'b0;
                    beat_d       = '0;
                    last_grant_d = 1'b1;
                    state_d      = StWr;
                end
            end
            StRd: begin
                if (issue) begin
                    ram_en = 1'b1;
                    beat_d = beat_q + 9'd1;
                end
                if (pop && head_last) begin
                    sk_v_d  = 1'b0;
                    ram_v_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StWr: begin
                axi64.wready = 1'b1;
                if (axi64.wvalid) begin
                    ram_en = !err_q;
                    ram_we = 1'b1;
                    ram_be = axi64.wstrb;
                    beat_d = beat_q + 9'd1;
                    if (axi64.wlast != beat_is_last) begin
                        wl_err_d = 1'b1;
                    end
                    if (beat_is_last) begin
                        state_d = StWresp;
                    end
                end
            end
            StWresp: begin
                axi64.bvalid = 1'b1;
                axi64.bresp  = (err_q || wl_err_q) ? RespSlverr : RespOkay;
                if (axi64.bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            id_q         <= '0;
            base_q       <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            wl_err_q     <= 1'b0;
            beat_q       <= '0;
            last_grant_q <= 1'b1;
            sk_v_q       <= 1'b0;
            sk_data_q    <= '0;
            sk_last_q    <= 1'b0;
            ram_v_q      <= 1'b0;
            ram_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            base_q       <= base_d;
            len_q        <= len_d;
            err_q        <= err_d;
            wl_err_q     <= wl_err_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            sk_v_q       <= sk_v_d;
            sk_data_q    <= sk_data_d;
            sk_last_q    <= sk_last_d;
            ram_v_q      <= ram_v_d;
            ram_last_q   <= ram_last_d;
        end
    end

endmodule

// File: doc/axi64_slave_ram.md
# axi64_slave_ram

AXI4 64-bit slave memory that answers the vector unit's `axi64` master port: accepts INCR read and write bursts on one single-ported, byte-enabled RAM and returns R beats and B responses tagged with the request ID. It sits on the fabric side of the vector unit's memory port. It is used as the vector unit's local scratch memory and as the target for the vector load/store bench.

## Interface
- `MEM_BYTES`, 65536: RAM size in bytes, power of two, multiple of 8.
- `ID_WIDTH`, 6: AXI ID width; matches the vector unit's ID width.
- `clk` in, 1: the single clock.
- `rst` in, 1: reset, synchronous, active-high.
- `axi64` slave modport, `axi64_interface.slave`, covers the AR, R, AW, W and B channels:
  - 32-bit address, 64-bit data, 8-bit strobe, 8-bit len, 3-bit size, 2-bit burst, ID_WIDTH ids.
  - `arcache` and `awcache` are ignored.

## Operation
- **Addressing**
  - Word index = (addr >> 3) + beat, taken modulo MEM_BYTES/8.
  - addr[2:0] is ignored; the start address is aligned down.
  - Upper address bits beyond the RAM size are ignored, so accesses wrap.
- **Supported bursts:** size 3'b011, burst INCR (2'b01) or FIXED (2'b00); FIXED is treated as INCR.
- **Unsupported bursts:** any other size, or burst WRAP.
  - The burst still completes len+1 beats.
  - Reads return zero data with rresp=SLVERR.
  - Writes are dropped and bresp=SLVERR.
- **FSM states:** IDLE, RD, WR, WRESP.
- **IDLE**
  - arready is high only if the read is granted; awready is high only if the write is granted. Both are combinational from state and grant.
  - Grant rules:
    - If only arvalid is high, the read is granted.
    - If only awvalid is high, the write is granted.
    - If both are high, alternate against a `last_grant` flag.
  - On the AR handshake: latch id, addr, len and the error flag, clear the beat counter, go to RD.
  - On the AW handshake: the same latches, then go to WR.
- **RD**
  - Issue one RAM read per cycle while the 2-entry output buffer has room; beat k is tagged rlast when k==len.
  - rid equals the latched id on every beat.
  - Exit to IDLE in the cycle the rlast beat handshakes.
- **WR**
  - wready is high every cycle. Each W handshake writes wdata under wstrb into the RAM and increments the beat count.
  - After beat len, go to WRESP.
  - wlast protocol error: wlast is low on beat len, or high on an earlier beat. The result is bresp=SLVERR; the beat count (len) alone ends the burst.
- **WRESP:** bvalid is high with bid = latched id; on the bready handshake go to IDLE.
- **Invariants**
  - Only one burst is in flight at a time.
  - Reads and writes never overlap.
  - There is no reordering.
- **Reset** (applies even mid-burst):
  - State returns to IDLE.
  - Output buffer cleared, beat counter 0.
  - `last_grant` set to write, so the first tie goes to the read.
  - RAM contents are preserved, not reset.
  - Any in-flight burst is abandoned with no response.

## Timing
- **Reset values:** arready, awready, rvalid, wready, bvalid = 0; rlast = 0; rdata, rid, bid, rresp, bresp = 0.
- **Read latency**
  - AR handshake in cycle T.
  - RAM read of beat 0 in T+1.
  - rvalid for beat 0 in T+2.
  - With rready held high, one beat per cycle; the last beat is at T+2+len.
  - A new AR can be accepted at T+3+len.
- **Read backpressure**
  - With rready low, rvalid and rdata hold stable; at most 2 beats are buffered and RAM reads stall.
  - When rready rises, full throughput resumes with no bubble.
- **Write latency**
  - AW handshake in cycle T.
  - wready from T+1.
  - The last W handshake is at T+1+len with no stall.
  - bvalid at T+2+len.
- **Read-after-write:** a write byte is visible to a read whose AR is accepted after the B handshake.
- **Handshake rules:** no output valid depends combinationally on the corresponding ready.

## Structure
- **Shared package:** `cfu_types` holds:
  - AXI response encodings: OKAY 2'b00, SLVERR 2'b10.
  - Burst encodings: FIXED, INCR, WRAP.
  - The size constant 3'b011.
  - The slave FSM state enum.
- **Sub-module:** `byte_en_ram` — single-port, 64-bit wide, 8 byte-enables, registered read, 1-cycle latency.
- **Top block:** the FSM, arbitration, counters and the 2-entry R buffer.

## Test plan
- Write burst: addr 0x100, len 3, data 0x1111..., 0x2222..., 0x3333..., 0x4444..., full strobes, bready=1.
  - Expect bvalid at T+5, bresp=OKAY, bid equal to awid.
  - Then read burst addr 0x100, len 3: the same 4 words in order, rlast on the 4th beat only, rresp=OKAY.
- Partial strobe: word 0x200 preset to 0xFFFF_FFFF_FFFF_FFFF; write 0 with wstrb=8'h0F.
  - Expect the read to return 0xFFFF_FFFF_0000_0000.
- Read backpressure: read len 7 with rready toggling 1,0,0,1,...
  - Expect 8 beats in order.
  - rdata and rvalid stable while stalled.
  - No beat lost or duplicated.
- Simultaneous arvalid and awvalid from reset:
  - Expect the read granted first, then the write.
  - For the next tie, the read is granted again (alternation).
- Error cases:
  - arsize=3'b010: expect 4 beats of zero data, rresp=SLVERR.
  - Write len 1 with wlast on beat 0: expect bresp=SLVERR, and both beats written.
- Wrap and reset:
  - Write at addr MEM_BYTES-8 with len 1: expect the second beat lands at word 0.
  - rst asserted mid-read: expect rvalid=0 the next cycle, and a new AR accepted.
